// File: rtl/patch_result_tx_if.sv
// Patch-result TX link: reducer record handshake plus the
// FPGA-to-PC FIFO write port, grouped for one port connection.
interface patch_result_tx_if #(
  parameter int XB_SIZE      = 32,
  parameter int FP_SIZE      = 32,
  parameter int N_FRAME_SIZE = 20,
  parameter int N_PATCH_SIZE = 20
);
  logic                    in_valid;
  logic                    in_rdy;
  logic                    in_eof;
  logic [N_FRAME_SIZE-1:0] in_frame;
  logic [N_PATCH_SIZE-1:0] in_num;
  logic [FP_SIZE-1:0]      in_sum;
  logic                    fpga_msg_full;
  logic                    fpga_msg_valid;
  logic [XB_SIZE-1:0]      fpga_msg;

  modport master (
    output in_valid,
    output in_eof,
    output in_frame,
    output in_num,
    output in_sum,
    output fpga_msg_full,
    input  in_rdy,
    input  fpga_msg_valid,
    input  fpga_msg
  );

  modport slave (
    input  in_valid,
    input  in_eof,
    input  in_frame,
    input  in_num,
    input  in_sum,
    input  fpga_msg_full,
    output in_rdy,
    output fpga_msg_valid,
    output fpga_msg
  );
endinterface

// File: rtl/patch_result_tx.sv
// Serializes patch results and EOF markers into tagged 32-bit
// words for the FPGA-to-PC FIFO, with message seq and result count.
module patch_result_tx #(
  parameter int XB_SIZE      = 32,
  parameter int FP_SIZE      = 32,
  parameter int N_FRAME_SIZE = 20,
  parameter int N_PATCH_SIZE = 20
) (
  input  logic             bus_clk,
  input  logic             reset_n,
  patch_result_tx_if.slave io,
  output logic             error
);

  typedef enum logic [2:0] {
    IDLE,
    RES_W0,
    RES_W1,
    RES_W2,
    EOF_W0,
    EOF_W1
  } state_t;

  state_t state_q, state_d, nxt;

  logic [9:0]              seq_q, seq_d;
  logic [9:0]              mseq_q, mseq_d;
  logic [31:0]             n_result_q, n_result_d;
  logic [N_PATCH_SIZE-1:0] num_q, num_d;
  logic [N_FRAME_SIZE-1:0] frame_q, frame_d;
  logic [XB_SIZE-1:0]      data_q, data_d;
  logic                    valid_q, valid_d;
  logic [XB_SIZE-1:0]      msg_q, msg_d;
  logic                    error_q, error_d;
  logic [XB_SIZE-1:0]      word;
  logic                    rdy;
  logic                    accept;

  assign rdy    = (state_q == IDLE) && reset_n;
  assign accept = io.in_valid && rdy;

  assign io.in_rdy         = rdy;
  assign io.fpga_msg_valid = valid_q;
  assign io.fpga_msg       = msg_q;
  assign error             = error_q;

  always_comb begin
    word = msg_q;
    nxt  = IDLE;
    unique case (state_q)
      RES_W0: begin
        word = XB_SIZE'({num_q, mseq_q, 2'b10});
        nxt  = RES_W1;
      end
      RES_W1: begin
        word = XB_SIZE'({frame_q, 12'h000});
        nxt  = RES_W2;
      end
      RES_W2: begin
        word = data_q;
        nxt  = IDLE;
      end
      EOF_W0: begin
        word = XB_SIZE'({frame_q, mseq_q, 2'b11});
        nxt  = EOF_W1;
      end
      EOF_W1: begin
        word = data_q;
        nxt  = IDLE;
      end
      default: begin
        word = msg_q;
        nxt  = IDLE;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    mseq_d     = mseq_q;
    n_result_d = n_result_q;
    num_d      = num_q;
    frame_d    = frame_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    msg_d      = msg_q;
    error_d    = error_q;
    if (state_q == IDLE) begin
      if (accept) begin
        mseq_d  = seq_q;
        seq_d   = seq_q + 10'd1;
        num_d   = io.in_num;
        frame_d = io.in_frame;
        if (io.in_eof) begin
          data_d     = XB_SIZE'(n_result_q);
          n_result_d = '0;
          state_d    = EOF_W0;
        end else begin
          data_d  = XB_SIZE'(io.in_sum);
          state_d = RES_W0;
          // saturate instead of wrapping; error is sticky
          if (n_result_q == '1) begin
            error_d = 1'b1;
          end else begin
            n_result_d = n_result_q + 32'd1;
          end
        end
      end
    end else if (!io.fpga_msg_full) begin
      valid_d = 1'b1;
      msg_d   = word;
      state_d = nxt;
    end
  end

  always_ff @(posedge bus_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      seq_q      <= '0;
      mseq_q     <= '0;
      n_result_q <= '0;
      num_q      <= '0;
      frame_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      msg_q      <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      mseq_q     <= mseq_d;
      n_result_q <= n_result_d;
      num_q      <= num_d;
      frame_q    <= frame_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      msg_q      <= msg_d;
      error_q    <= error_d;
    end
  end

endmodule
